sd_feed_ctrl: RTL and testbench

// - Sequencer for the serial sequence detector (SD): takes parallel words over valid/ready, feeds them
//   MSB-first to the detector's sequence_in with no gaps, controls the detector's reset and counts hits.
// - Sits between a word-stream producer and one SD instance; the SD needs no changes.

---
 rtl/sd_feed_ctrl.sv | 151 +++++++++++++++
 tb/tb_sd_feed_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_feed_ctrl.sv
// sd_feed_ctrl: feeds a valid/ready word stream MSB-first, gap-free, into a serial sequence detector and counts hits.
// Optional abort input is compiled in when SD_FEED_ABORT_EN is defined.
module sd_feed_ctrl #(
    parameter int WORD_W       = 8,
    parameter int CNT_W        = 16,
    parameter int RST_CYCLES   = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_last,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              seq_out,
    output logic              det_rst,
    input  logic              det_in,
    output logic              hit_pulse,
    output logic [CNT_W-1:0]  hit_count,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef SD_FEED_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam int BW   = $clog2(WORD_W);
    localparam int TMAX = (RST_CYCLES > FLUSH_CYCLES) ? RST_CYCLES : FLUSH_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] sreg;
    logic [BW-1:0]     bitcnt;
    logic              last_q;
    logic [TW-1:0]     timer;

    logic boundary;
    logic transfer;
    logic abort_req;
    logic count_en;

    // Everything below decodes registered state only, so no input reaches an output combinationally.
    assign boundary   = (state == SHIFT) && (bitcnt == '0);
    assign word_ready = (state == LOAD) || (boundary && !last_q);
    assign transfer   = word_valid && word_ready;
    assign seq_out    = (state == SHIFT) && sreg[WORD_W-1];
    assign det_rst    = !((state == SHIFT) || (state == DRAIN));
    assign busy       = (state != IDLE);
    assign count_en   = ((state == SHIFT) || (state == DRAIN)) && det_in;

`ifdef SD_FEED_ABORT_EN
    assign abort_req = abort && busy;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sreg      <= '0;
            bitcnt    <= '0;
            last_q    <= 1'b0;
            timer     <= '0;
            hit_pulse <= 1'b0;
            hit_count <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done      <= 1'b0;
            hit_pulse <= 1'b0;
            if (abort_req) begin
                state <= IDLE;
            end else begin
                if (count_en) begin
                    hit_pulse <= 1'b1;
                    if (hit_count != '1)
                        hit_count <= hit_count + CNT_W'(1);
                end
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= CLEAR;
                            timer     <= '0;
                            hit_count <= '0;
                            err       <= 1'b0;
                        end
                    end
                    CLEAR: begin
                        if (timer == TW'(RST_CYCLES - 1))
                            state <= LOAD;
                        else
                            timer <= timer + TW'(1);
                    end
                    LOAD: begin
                        if (transfer) begin
                            sreg   <= word_in;
                            last_q <= word_last;
                            bitcnt <= BW'(WORD_W - 1);
                            state  <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (bitcnt != '0) begin
                            sreg   <= {sreg[WORD_W-2:0], 1'b0};
                            bitcnt <= bitcnt - BW'(1);
                        end else if (last_q) begin
                            state <= DRAIN;
                            timer <= '0;
                        end else if (transfer) begin
                            // Reload in the last-bit cycle keeps the bit stream gapless across words.
                            sreg   <= word_in;
                            last_q <= word_last;
                            bitcnt <= BW'(WORD_W - 1);
                        end else begin
                            err   <= 1'b1;
                            state <= CLEAR;
                            timer <= '0;
                        end
                    end
                    DRAIN: begin
                        if (timer == TW'(FLUSH_CYCLES - 1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_feed_ctrl.sv
// tb_sd_feed_ctrl: directed bench driving sd_feed_ctrl with a behavioural overlapping Moore "1011" detector.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_sd_feed_ctrl;

    logic       clock      = 1'b0;
    logic       reset      = 1'b0;
    logic       start      = 1'b0;
    logic [7:0] word_in    = 8'h00;
    logic       word_last  = 1'b0;
    logic       word_valid = 1'b0;
`ifdef SD_FEED_ABORT_EN
    logic       abort      = 1'b0;
`endif

    logic        word_ready, seq_out, det_rst, det_in, hit_pulse, busy, done, err;
    logic [15:0] hit_count;
    logic        s_word_ready, s_seq_out, s_det_rst, s_det_in, s_hit_pulse, s_busy, s_done, s_err;
    logic [1:0]  s_hit_count;

    logic [2:0]  det_st   = 3'd0;
    logic [2:0]  s_det_st = 3'd0;

    int          checks = 0;
    int          errors = 0;
    int          nbits = 0, readyCycles = 0, pulseCount = 0, satPulseCount = 0, doneCount = 0;
    logic [63:0] bits = 64'd0;

    always #5 clock = ~clock;

    sd_feed_ctrl #(.WORD_W(8), .CNT_W(16), .RST_CYCLES(2), .FLUSH_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .start(start), .word_in(word_in), .word_last(word_last),
        .word_valid(word_valid), .word_ready(word_ready), .seq_out(seq_out), .det_rst(det_rst),
        .det_in(det_in), .hit_pulse(hit_pulse), .hit_count(hit_count), .busy(busy), .done(done),
        .err(err)
`ifdef SD_FEED_ABORT_EN
        , .abort(abort)
`endif
    );

    sd_feed_ctrl #(.WORD_W(8), .CNT_W(2), .RST_CYCLES(2), .FLUSH_CYCLES(2)) dut_sat (
        .clock(clock), .reset(reset), .start(start), .word_in(word_in), .word_last(word_last),
        .word_valid(word_valid), .word_ready(s_word_ready), .seq_out(s_seq_out), .det_rst(s_det_rst),
        .det_in(s_det_in), .hit_pulse(s_hit_pulse), .hit_count(s_hit_count), .busy(s_busy),
        .done(s_done), .err(s_err)
`ifdef SD_FEED_ABORT_EN
        , .abort(abort)
`endif
    );

    // Overlapping Moore "1011": states count matched prefix length, state 4 = full match.
    function automatic logic [2:0] detNext(input logic [2:0] st, input logic b);
        case (st)
            3'd0:    return b ? 3'd1 : 3'd0;
            3'd1:    return b ? 3'd1 : 3'd2;
            3'd2:    return b ? 3'd3 : 3'd0;
            3'd3:    return b ? 3'd4 : 3'd2;
            3'd4:    return b ? 3'd1 : 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    always @(posedge clock) begin
        det_st   <= det_rst   ? 3'd0 : detNext(det_st, seq_out);
        s_det_st <= s_det_rst ? 3'd0 : detNext(s_det_st, s_seq_out);
    end
    assign det_in   = (det_st == 3'd4);
    assign s_det_in = (s_det_st == 3'd4);

    // Record every bit the detector actually sees, plus per-run event counts.
    always @(negedge clock) begin
        if (!det_rst) begin
            bits  = {bits[62:0], seq_out};
            nbits = nbits + 1;
        end
        if (word_ready)  readyCycles   = readyCycles + 1;
        if (hit_pulse)   pulseCount    = pulseCount + 1;
        if (s_hit_pulse) satPulseCount = satPulseCount + 1;
        if (done)        doneCount     = doneCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearCounters();
        nbits = 0; readyCycles = 0; pulseCount = 0; satPulseCount = 0; doneCount = 0;
        bits  = 64'd0;
    endtask

    task automatic pulseStart();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    // Offer one word and hold it until the controller takes it.
    task automatic applyStimulus(input logic [7:0] w, input logic l);
        bit got = 1'b0;
        word_in = w; word_last = l; word_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (word_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!got) checkOutput("ready_timeout", 64'd0, 64'd1);
        @(posedge clock); #1 word_valid = 1'b0;
    endtask

    task automatic waitDone();
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) checkOutput("done_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit got;

        // Reset state.
        #1;
        checkOutput("rst_busy",      64'(busy),       64'd0);
        checkOutput("rst_det_rst",   64'(det_rst),    64'd1);
        checkOutput("rst_seq_out",   64'(seq_out),    64'd0);
        checkOutput("rst_ready",     64'(word_ready), 64'd0);
        checkOutput("rst_hit_count", 64'(hit_count),  64'd0);
        checkOutput("rst_err",       64'(err),        64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Single word 1011_0000 with last.
        clearCounters();
        pulseStart();
        applyStimulus(8'hB0, 1'b1);
        waitDone();
        checkOutput("t1_hits",   64'(hit_count),   64'd1);
        checkOutput("t1_err",    64'(err),         64'd0);
        checkOutput("t1_nbits",  64'(nbits),       64'd10);
        checkOutput("t1_bits",   bits & 64'h3FF,   64'h2C0);
        checkOutput("t1_done",   64'(doneCount),   64'd1);
        checkOutput("t1_busy",   64'(busy),        64'd0);
        checkOutput("t1_pulses", 64'(pulseCount),  64'd1);
        checkOutput("t1_ready",  64'(readyCycles), 64'd1);

        // Gapless 05 then 80: match spans the word boundary.
        clearCounters();
        pulseStart();
        applyStimulus(8'h05, 1'b0);
        applyStimulus(8'h80, 1'b1);
        waitDone();
        checkOutput("t2_hits",  64'(hit_count),   64'd1);
        checkOutput("t2_nbits", 64'(nbits),       64'd18);
        checkOutput("t2_bits",  bits & 64'h3FFFF, 64'h1600);
        checkOutput("t2_ready", 64'(readyCycles), 64'd2);

        // Overlapping matches; a start pulse mid-run must be ignored.
        clearCounters();
        pulseStart();
        applyStimulus(8'hB6, 1'b1);
        pulseStart();
        checkOutput("t3_busy_mid", 64'(busy), 64'd1);
        waitDone();
        checkOutput("t3_hits",     64'(hit_count),     64'd2);
        checkOutput("t3_pulses",   64'(pulseCount),    64'd2);
        checkOutput("t3_nbits",    64'(nbits),         64'd10);
        checkOutput("t3_bits",     bits & 64'h3FF,     64'h2D8);
        checkOutput("t3_sat_hits", 64'(s_hit_count),   64'd2);
        checkOutput("t3_done",     64'(doneCount),     64'd1);

        // Underrun after a non-last word, then recovery.
        clearCounters();
        pulseStart();
        applyStimulus(8'h00, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (word_ready) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("t4_boundary", 64'(got), 64'd1);
        @(negedge clock);
        checkOutput("t4_err",       64'(err),        64'd1);
        checkOutput("t4_clr1_rst",  64'(det_rst),    64'd1);
        checkOutput("t4_clr1_rdy",  64'(word_ready), 64'd0);
        @(negedge clock);
        checkOutput("t4_clr2_rst",  64'(det_rst),    64'd1);
        checkOutput("t4_clr2_rdy",  64'(word_ready), 64'd0);
        @(negedge clock);
        checkOutput("t4_load_rdy",  64'(word_ready), 64'd1);
        checkOutput("t4_load_rst",  64'(det_rst),    64'd1);
        applyStimulus(8'hB0, 1'b1);
        waitDone();
        checkOutput("t4_hits",  64'(hit_count), 64'd1);
        checkOutput("t4_done",  64'(doneCount), 64'd1);
        checkOutput("t4_err2",  64'(err),       64'd1);
        checkOutput("t4_nbits", 64'(nbits),     64'd18);
        checkOutput("t4_bits",  bits & 64'h3FFFF, 64'h2C0);

        // BB BB: four hits, narrow counter saturates at 3.
        clearCounters();
        pulseStart();
        checkOutput("t5_err_clr", 64'(err), 64'd0);
        applyStimulus(8'hBB, 1'b0);
        applyStimulus(8'hBB, 1'b1);
        waitDone();
        checkOutput("t5_hits",       64'(hit_count),     64'd4);
        checkOutput("t5_pulses",     64'(pulseCount),    64'd4);
        checkOutput("t5_sat_hits",   64'(s_hit_count),   64'd3);
        checkOutput("t5_sat_pulses", 64'(satPulseCount), 64'd4);

        // Asynchronous reset in the middle of SHIFT.
        clearCounters();
        pulseStart();
        applyStimulus(8'hB0, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (hit_count == 16'd1) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("t6_pre_hit", 64'(got), 64'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("t6_busy",      64'(busy),       64'd0);
        checkOutput("t6_det_rst",   64'(det_rst),    64'd1);
        checkOutput("t6_seq_out",   64'(seq_out),    64'd0);
        checkOutput("t6_ready",     64'(word_ready), 64'd0);
        checkOutput("t6_hit_count", 64'(hit_count),  64'd0);
        checkOutput("t6_hit_pulse", 64'(hit_pulse),  64'd0);
        checkOutput("t6_done",      64'(done),       64'd0);
        @(posedge clock);
        #1 reset = 1'b1;

`ifdef SD_FEED_ABORT_EN
        // Abort during SHIFT: back to IDLE, no done pulse.
        clearCounters();
        pulseStart();
        applyStimulus(8'hB0, 1'b0);
        @(negedge clock);
        abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        checkOutput("t7_busy",    64'(busy),    64'd0);
        checkOutput("t7_det_rst", 64'(det_rst), 64'd1);
        repeat (12) @(negedge clock);
        checkOutput("t7_done",    64'(doneCount), 64'd0);
        checkOutput("t7_err",     64'(err),       64'd0);
        checkOutput("t7_idle",    64'(busy),      64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
